// File: rtl/rx_deserializer.sv
// Serial frame receiver: synchronizes a remote serial clock and data line into the
// i_Pclk domain and assembles start/data/parity/stop bits into an 11-bit frame.
module rx_deserializer (
    input  logic        i_Pclk,
    input  logic        i_Rst,
    input  logic        i_SerClk,
    input  logic        i_Rx,
    input  logic [1:0]  i_Parity,
    output logic [10:0] o_Frame,
    output logic        o_Valid,
    output logic        o_FrameErr,
    output logic        o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DATA      = 3'd1,
        S_PARITY    = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  fmt_q, fmt_d;
    logic [10:0] frame_q, frame_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q;

    logic        serclk_s1_q, serclk_s2_q, serclk_prev_q;
    logic        rx_s1_q, rx_s2_q;
    logic        tick_s;
    logic        rx_s;

    // Both serial inputs use identical 2-flop paths so data stays aligned with its clock edge.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            serclk_s1_q   <= 1'b0;
            serclk_s2_q   <= 1'b0;
            serclk_prev_q <= 1'b0;
            rx_s1_q       <= 1'b0;
            rx_s2_q       <= 1'b0;
        end else begin
            serclk_s1_q   <= i_SerClk;
            serclk_s2_q   <= serclk_s1_q;
            serclk_prev_q <= serclk_s2_q;
            rx_s1_q       <= i_Rx;
            rx_s2_q       <= rx_s1_q;
        end
    end

    assign tick_s = serclk_s2_q & ~serclk_prev_q;
    assign rx_s   = rx_s2_q;

    // Frame-assembly FSM: next state, shift register and output staging.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        fmt_d   = fmt_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (tick_s) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d     = S_DATA;
                        shift_d[10] = 1'b0;
                        count_d     = 3'd0;
                        fmt_d       = i_Parity;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    shift_d[4'd9 - {1'b0, count_q}] = rx_s;
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        if ((fmt_q == 2'b01) || (fmt_q == 2'b10)) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d    = S_STOP;
                            shift_d[1] = 1'b0;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: begin
                    shift_d[1] = rx_s;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    shift_d[0] = rx_s;
                    frame_d    = {shift_q[10:1], rx_s};
                    valid_d    = 1'b1;
                    err_d      = ~rx_s;
                    state_d    = rx_s ? S_IDLE : S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    // A held-low break must see a 1 before another start bit is accepted.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs; reset discards any partially received frame.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            shift_q <= 11'h000;
            count_q <= 3'd0;
            fmt_q   <= 2'b00;
            frame_q <= 11'h000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            fmt_q   <= fmt_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign o_Frame    = frame_q;
    assign o_Valid    = valid_q;
    assign o_FrameErr = err_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: bit-level serial stimulus with hand-computed
// expected frames, latency, busy and frame-error checks.
module tb_rx_deserializer;

    logic        i_Pclk;
    logic        i_Rst;
    logic        i_SerClk;
    logic        i_Rx;
    logic [1:0]  i_Parity;
    logic [10:0] o_Frame;
    logic        o_Valid;
    logic        o_FrameErr;
    logic        o_Busy;

    int tests;
    int fails;
    int vcnt;

    rx_deserializer dut (
        .i_Pclk     (i_Pclk),
        .i_Rst      (i_Rst),
        .i_SerClk   (i_SerClk),
        .i_Rx       (i_Rx),
        .i_Parity   (i_Parity),
        .o_Frame    (o_Frame),
        .o_Valid    (o_Valid),
        .o_FrameErr (o_FrameErr),
        .o_Busy     (o_Busy)
    );

    initial i_Pclk = 1'b0;
    always #5 i_Pclk = ~i_Pclk;

    // Counts every cycle o_Valid is high; a pulse per frame means one count per frame.
    always @(negedge i_Pclk) begin
        if (o_Valid === 1'b1) vcnt++;
    end

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One serial bit: data set while the serial clock is low, rising edge mid-bit.
    task automatic send_bit(input logic b);
        @(negedge i_Pclk);
        i_Rx     = b;
        i_SerClk = 1'b0;
        repeat (3) @(negedge i_Pclk);
        i_SerClk = 1'b1;
        repeat (4) @(negedge i_Pclk);
    endtask

    // Stop bit with exact latency checks around the o_Valid pulse.
    task automatic send_stop(input string tag, input logic b, input logic [10:0] exp_frame,
                             input logic exp_err, input logic exp_busy);
        @(negedge i_Pclk);
        i_Rx     = b;
        i_SerClk = 1'b0;
        repeat (3) @(negedge i_Pclk);
        i_SerClk = 1'b1;
        @(negedge i_Pclk);
        @(negedge i_Pclk);
        check({tag, " valid_early"}, {10'd0, o_Valid}, 11'd0);
        @(negedge i_Pclk);
        check({tag, " valid"}, {10'd0, o_Valid}, 11'd1);
        check({tag, " frame"}, o_Frame, exp_frame);
        check({tag, " err"}, {10'd0, o_FrameErr}, {10'd0, exp_err});
        check({tag, " busy_after"}, {10'd0, o_Busy}, {10'd0, exp_busy});
        @(negedge i_Pclk);
        check({tag, " valid_pulse"}, {10'd0, o_Valid}, 11'd0);
        check({tag, " frame_hold"}, o_Frame, exp_frame);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] data, input logic has_par,
                              input logic par, input logic stop, input logic [10:0] exp_frame,
                              input logic exp_err, input logic exp_busy);
        send_bit(1'b0);
        check({tag, " busy_start"}, {10'd0, o_Busy}, 11'd1);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        if (has_par) send_bit(par);
        send_stop(tag, stop, exp_frame, exp_err, exp_busy);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        vcnt     = 0;
        i_Rst    = 1'b1;
        i_SerClk = 1'b0;
        i_Rx     = 1'b1;
        i_Parity = 2'b00;
        repeat (3) @(negedge i_Pclk);
        check("rst frame", o_Frame, 11'h000);
        check("rst valid", {10'd0, o_Valid}, 11'd0);
        check("rst err", {10'd0, o_FrameErr}, 11'd0);
        check("rst busy", {10'd0, o_Busy}, 11'd0);
        i_Rst = 1'b0;
        repeat (4) @(negedge i_Pclk);

        // Idle ticks with line high keep the receiver idle.
        send_bit(1'b1);
        send_bit(1'b1);
        check("idle busy", {10'd0, o_Busy}, 11'd0);
        check("idle vcnt", vcnt[10:0], 11'd0);

        i_Parity = 2'b01;
        send_frame("even_A5", 8'hA5, 1'b1, 1'b0, 1'b1, 11'b0_10100101_0_1, 1'b0, 1'b0);
        check("even_A5 vcnt", vcnt[10:0], 11'd1);

        i_Parity = 2'b00;
        send_bit(1'b1);
        send_frame("nopar_3C", 8'h3C, 1'b0, 1'b0, 1'b1, 11'b0_00111100_0_1, 1'b0, 1'b0);
        check("nopar_3C vcnt", vcnt[10:0], 11'd2);

        // Break: stop sampled low, line stays low for several ticks.
        i_Parity = 2'b10;
        send_bit(1'b1);
        send_frame("odd_FF_err", 8'hFF, 1'b1, 1'b1, 1'b0, 11'b0_11111111_1_0, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("break busy", {10'd0, o_Busy}, 11'd1);
        check("break vcnt", vcnt[10:0], 11'd3);
        send_bit(1'b1);
        check("break release busy", {10'd0, o_Busy}, 11'd0);

        // Reset after four data ticks aborts the frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("pre_rst busy", {10'd0, o_Busy}, 11'd1);
        @(negedge i_Pclk);
        i_Rx     = 1'b1;
        i_SerClk = 1'b0;
        i_Rst    = 1'b1;
        @(negedge i_Pclk);
        check("mid_rst busy", {10'd0, o_Busy}, 11'd0);
        check("mid_rst valid", {10'd0, o_Valid}, 11'd0);
        i_Rst = 1'b0;
        repeat (6) @(negedge i_Pclk);
        check("mid_rst vcnt", vcnt[10:0], 11'd3);
        i_Parity = 2'b10;
        send_frame("after_rst_81", 8'h81, 1'b1, 1'b1, 1'b1, 11'b0_10000001_1_1, 1'b0, 1'b0);
        check("after_rst vcnt", vcnt[10:0], 11'd4);

        // Format change mid-frame applies only from the next start bit.
        i_Parity = 2'b01;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        i_Parity = 2'b00;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_stop("fmt_switch_13", 1'b1, 11'b0_00010011_1_1, 1'b0, 1'b0);
        send_bit(1'b1);
        send_frame("fmt_next_5A", 8'h5A, 1'b0, 1'b0, 1'b1, 11'b0_01011010_0_1, 1'b0, 1'b0);
        check("fmt vcnt", vcnt[10:0], 11'd6);

        // Back-to-back frames, format 11 behaves as no parity.
        i_Parity = 2'b11;
        send_bit(1'b1);
        send_frame("b2b_C3", 8'hC3, 1'b0, 1'b0, 1'b1, 11'b0_11000011_0_1, 1'b0, 1'b0);
        send_frame("b2b_0F", 8'h0F, 1'b0, 1'b0, 1'b1, 11'b0_00001111_0_1, 1'b0, 1'b0);
        check("b2b vcnt", vcnt[10:0], 11'd8);

        repeat (4) @(negedge i_Pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
